// File: rtl/param_dpram.sv
// param_dpram: single-clock true dual-port RAM with per-byte write enables,
// 1- or 2-cycle read latency and selectable cross-port read-during-write
// result (RDW_MODE 0 = old word, 1 = byte-merged new word).
// Optional collision reporting (coll / coll_addr) is built only when the
// macro PARAM_DPRAM_COLL_EN is defined.
module param_dpram #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid
`ifdef PARAM_DPRAM_COLL_EN
    ,
    output logic                coll,
    output logic [ADDR_W-1:0]   coll_addr
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              a_wr, a_rd, b_wr, b_rd, same_addr;
    logic [DATA_W-1:0] a_rd_d, b_rd_d, a_wr_d, b_wr_d;

    logic              a_v1_q, b_v1_q;
    logic [DATA_W-1:0] a_d1_q, b_d1_q;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    assign a_wr      = a_en &  a_we;
    assign a_rd      = a_en & ~a_we;
    assign b_wr      = b_en &  b_we;
    assign b_rd      = b_en & ~b_we;
    assign same_addr = (a_addr == b_addr);

    // Read words (with optional cross-port bypass) and merged write words.
    // On a same-address double write, A's word is built on top of B's merge
    // so A wins overlapping bytes while B's other bytes survive.
    always_comb begin
        a_rd_d = mem_q[a_addr];
        b_rd_d = mem_q[b_addr];
        if (RDW_MODE == 1) begin
            if (b_wr && same_addr) a_rd_d = merge_bytes(a_rd_d, b_wdata, b_be);
            if (a_wr && same_addr) b_rd_d = merge_bytes(b_rd_d, a_wdata, a_be);
        end
        b_wr_d = merge_bytes(mem_q[b_addr], b_wdata, b_be);
        a_wr_d = merge_bytes(mem_q[a_addr], a_wdata, a_be);
        if (b_wr && same_addr) a_wr_d = merge_bytes(b_wr_d, a_wdata, a_be);
    end

    // Memory array: never cleared; writes are dropped while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
            if (b_wr) mem_q[b_addr] <= b_wr_d;
            if (a_wr) mem_q[a_addr] <= a_wr_d;
        end
    end

    // First read stage: capture the word and flag a read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_v1_q <= 1'b0;
            b_v1_q <= 1'b0;
            a_d1_q <= '0;
            b_d1_q <= '0;
        end else begin
            a_v1_q <= a_rd;
            b_v1_q <= b_rd;
            if (a_rd) a_d1_q <= a_rd_d;
            if (b_rd) b_d1_q <= b_rd_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              a_v2_q, b_v2_q;
            logic [DATA_W-1:0] a_d2_q, b_d2_q;

            // Second read stage: data only moves on a valid so rdata holds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_v2_q <= 1'b0;
                    b_v2_q <= 1'b0;
                    a_d2_q <= '0;
                    b_d2_q <= '0;
                end else begin
                    a_v2_q <= a_v1_q;
                    b_v2_q <= b_v1_q;
                    if (a_v1_q) a_d2_q <= a_d1_q;
                    if (b_v1_q) b_d2_q <= b_d1_q;
                end
            end

            assign a_rvalid = a_v2_q;
            assign a_rdata  = a_d2_q;
            assign b_rvalid = b_v2_q;
            assign b_rdata  = b_d2_q;
        end else begin : g_lat1
            assign a_rvalid = a_v1_q;
            assign a_rdata  = a_d1_q;
            assign b_rvalid = b_v1_q;
            assign b_rdata  = b_d1_q;
        end
    endgenerate

`ifdef PARAM_DPRAM_COLL_EN
    logic              coll_d, coll_q;
    logic [ADDR_W-1:0] coll_addr_q;

    assign coll_d = a_en && b_en && same_addr && (a_we || b_we);

    // Collision flag pulses one cycle later; the address is held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q      <= 1'b0;
            coll_addr_q <= '0;
        end else begin
            coll_q <= coll_d;
            if (coll_d) coll_addr_q <= a_addr;
        end
    end

    assign coll      = coll_q;
    assign coll_addr = coll_addr_q;
`endif

endmodule

// File: tb/tb_param_dpram.sv
// Bench for param_dpram: two instances share stimulus (u0: RD_LAT=2 old-data,
// u1: RD_LAT=1 new-data). Directed table plus random traffic against a
// byte-level reference memory. Collision outputs checked when
// PARAM_DPRAM_COLL_EN is defined.
module tb_param_dpram;

    logic        clk;
    logic        rst;
    logic        en [2];
    logic        we [2];
    logic [3:0]  be [2];
    logic [5:0]  addr [2];
    logic [31:0] wd [2];
    logic [31:0] rdat [2][2];
    logic        rv [2][2];
`ifdef PARAM_DPRAM_COLL_EN
    logic        coll_o [2];
    logic [5:0]  caddr_o [2];
`endif

    param_dpram #(.DATA_W(32), .ADDR_W(6), .RD_LAT(2), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst),
        .a_en(en[0]), .a_we(we[0]), .a_be(be[0]), .a_addr(addr[0]), .a_wdata(wd[0]),
        .a_rdata(rdat[0][0]), .a_rvalid(rv[0][0]),
        .b_en(en[1]), .b_we(we[1]), .b_be(be[1]), .b_addr(addr[1]), .b_wdata(wd[1]),
        .b_rdata(rdat[0][1]), .b_rvalid(rv[0][1])
`ifdef PARAM_DPRAM_COLL_EN
        , .coll(coll_o[0]), .coll_addr(caddr_o[0])
`endif
    );

    param_dpram #(.DATA_W(32), .ADDR_W(6), .RD_LAT(1), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst),
        .a_en(en[0]), .a_we(we[0]), .a_be(be[0]), .a_addr(addr[0]), .a_wdata(wd[0]),
        .a_rdata(rdat[1][0]), .a_rvalid(rv[1][0]),
        .b_en(en[1]), .b_we(we[1]), .b_be(be[1]), .b_addr(addr[1]), .b_wdata(wd[1]),
        .b_rdata(rdat[1][1]), .b_rvalid(rv[1][1])
`ifdef PARAM_DPRAM_COLL_EN
        , .coll(coll_o[1]), .coll_addr(caddr_o[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [31:0] ref_mem [64];
    bit          pv [2][2][4];
    logic [31:0] pd [2][2][4];
    logic [31:0] hold [2][2];
    bit          exp_coll;
    logic [5:0]  exp_caddr;
    int unsigned n;
    int          nvec;
    int          nerr;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            en[p] = 1'b0; we[p] = 1'b0; be[p] = '0; addr[p] = '0; wd[p] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("u%0d_%s_rvalid", k, p == 0 ? "a" : "b"),
                    {31'd0, rv[k][p]}, {31'd0, pv[k][p][n % 4]});
                if (pv[k][p][n % 4]) hold[k][p] = pd[k][p][n % 4];
                chk($sformatf("u%0d_%s_rdata", k, p == 0 ? "a" : "b"), rdat[k][p], hold[k][p]);
            end
`ifdef PARAM_DPRAM_COLL_EN
            chk($sformatf("u%0d_coll", k), {31'd0, coll_o[k]}, {31'd0, exp_coll});
            chk($sformatf("u%0d_coll_addr", k), {26'd0, caddr_o[k]}, {26'd0, exp_caddr});
`endif
        end
    endtask

    // One clock: model the request presented now, clock it, compare outputs.
    task automatic tick();
        logic [31:0] w;
        bit          c;
        int          q;
        int          s;
        c = 1'b0;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (en[p] && !we[p]) begin
                        q = 1 - p;
                        w = ref_mem[addr[p]];
                        if (k == 1 && en[q] && we[q] && addr[q] == addr[p]) begin
                            for (int j = 0; j < 4; j++)
                                if (be[q][j]) w[8*j +: 8] = wd[q][8*j +: 8];
                        end
                        s = int'((n + 32'(lat_of(k)) - 1) % 4);
                        pv[k][p][s] = 1'b1;
                        pd[k][p][s] = w;
                    end
                end
            end
            // Per byte: port A's enabled byte always wins over port B's.
            for (int j = 0; j < 4; j++) begin
                if (en[1] && we[1] && be[1][j] &&
                    !(en[0] && we[0] && be[0][j] && addr[0] == addr[1]))
                    ref_mem[addr[1]][8*j +: 8] = wd[1][8*j +: 8];
                if (en[0] && we[0] && be[0][j])
                    ref_mem[addr[0]][8*j +: 8] = wd[0][8*j +: 8];
            end
            c = en[0] && en[1] && addr[0] == addr[1] && (we[0] || we[1]);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp_coll  = 1'b0;
            exp_caddr = '0;
        end else begin
            exp_coll = c;
            if (c) exp_caddr = addr[0];
        end
        check_outputs();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                pv[k][p][n % 4] = 1'b0;
        n++;
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                hold[k][p] = '0;
                for (int s = 0; s < 4; s++) pv[k][p][s] = 1'b0;
            end
        exp_coll  = 1'b0;
        exp_caddr = '0;
        #1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rst_u%0d_p%0d_rvalid", k, p), {31'd0, rv[k][p]}, 32'd0);
                chk($sformatf("rst_u%0d_p%0d_rdata", k, p), rdat[k][p], 32'd0);
            end
    endtask

    typedef struct {
        logic        aen, awe;
        logic [3:0]  abe;
        logic [5:0]  aaddr;
        logic [31:0] awd;
        logic        ben, bwe;
        logic [3:0]  bbe;
        logic [5:0]  baddr;
        logic [31:0] bwd;
        int          chk_port;   // 0 none, 1 port A, 2 port B
        logic [31:0] exp0;       // old-data / 2-cycle instance
        logic [31:0] exp1;       // new-data / 1-cycle instance
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        input logic aen, input logic awe, input logic [3:0] abe, input logic [5:0] aaddr,
        input logic [31:0] awd,
        input logic ben, input logic bwe, input logic [3:0] bbe, input logic [5:0] baddr,
        input logic [31:0] bwd,
        input int cp, input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.aen = aen; v.awe = awe; v.abe = abe; v.aaddr = aaddr; v.awd = awd;
        v.ben = ben; v.bwe = bwe; v.bbe = bbe; v.baddr = baddr; v.bwd = bwd;
        v.chk_port = cp; v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    initial begin
        nvec = 0; nerr = 0; n = 0;
        rst = 1'b0;
        exp_coll = 1'b0; exp_caddr = '0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) hold[k][p] = '0;
        idle();

        // Reset state
        #2;
        assert_reset();
        tick();
        tick();
        rst = 1'b0;

        // Preload every word so the reference never depends on power-up contents
        for (int i = 0; i < 32; i++) begin
            en[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 6'(i);      wd[0] = $urandom;
            en[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 6'(i + 32); wd[1] = $urandom;
            tick();
        end
        idle();
        tick();

        // Directed table
        tbl.push_back(mk(1,1,4'hF,6'd5,32'hDEADBEEF, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(0,0,4'h0,6'd0,32'h0, 1,0,4'h0,6'd5,32'h0, 2,32'hDEADBEEF,32'hDEADBEEF));
        tbl.push_back(mk(1,1,4'hF,6'd3,32'h11223344, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(1,1,4'h5,6'd3,32'hAABBCCDD, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(0,0,4'h0,6'd0,32'h0, 1,0,4'h0,6'd3,32'h0, 2,32'h11BB33DD,32'h11BB33DD));
        tbl.push_back(mk(1,1,4'hF,6'd7,32'h0, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(1,1,4'hF,6'd7,32'h12345678, 1,0,4'h0,6'd7,32'h0, 2,32'h0,32'h12345678));
        tbl.push_back(mk(0,0,4'h0,6'd0,32'h0, 1,0,4'h0,6'd7,32'h0, 2,32'h12345678,32'h12345678));
        tbl.push_back(mk(1,1,4'hF,6'd9,32'hFFFF0000, 1,1,4'hF,6'd9,32'h0000FFFF, 0,32'h0,32'h0));
        tbl.push_back(mk(1,0,4'h0,6'd9,32'h0, 0,0,4'h0,6'd0,32'h0, 1,32'hFFFF0000,32'hFFFF0000));
        tbl.push_back(mk(1,1,4'hF,6'd10,32'h0, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(1,1,4'h0,6'd10,32'hFFFFFFFF, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(0,0,4'h0,6'd0,32'h0, 1,0,4'h0,6'd10,32'h0, 2,32'h0,32'h0));
        tbl.push_back(mk(1,1,4'hF,6'd11,32'h44444444, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(1,1,4'h3,6'd11,32'h11111111, 1,1,4'h6,6'd11,32'h22222222, 0,32'h0,32'h0));
        tbl.push_back(mk(1,0,4'h0,6'd11,32'h0, 0,0,4'h0,6'd0,32'h0, 1,32'h44221111,32'h44221111));
        tbl.push_back(mk(1,1,4'hF,6'd63,32'hCAFEF00D, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(0,0,4'h0,6'd0,32'h0, 1,0,4'h0,6'd63,32'h0, 2,32'hCAFEF00D,32'hCAFEF00D));
        tbl.push_back(mk(1,1,4'hF,6'd12,32'h01020304, 0,0,4'h0,6'd0,32'h0, 0,32'h0,32'h0));
        tbl.push_back(mk(1,0,4'h0,6'd12,32'h0, 1,1,4'hF,6'd12,32'h55667788, 1,32'h01020304,32'h55667788));

        foreach (tbl[i]) begin
            en[0] = tbl[i].aen; we[0] = tbl[i].awe; be[0] = tbl[i].abe;
            addr[0] = tbl[i].aaddr; wd[0] = tbl[i].awd;
            en[1] = tbl[i].ben; we[1] = tbl[i].bwe; be[1] = tbl[i].bbe;
            addr[1] = tbl[i].baddr; wd[1] = tbl[i].bwd;
            tick();
            idle();
            if (tbl[i].chk_port != 0)
                chk($sformatf("tbl%0d_u1", i), rdat[1][tbl[i].chk_port - 1], tbl[i].exp1);
            tick();
            if (tbl[i].chk_port != 0)
                chk($sformatf("tbl%0d_u0", i), rdat[0][tbl[i].chk_port - 1], tbl[i].exp0);
        end

        // Write then read on the very next cycle, followed by back-to-back reads
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 6'd20; wd[0] = 32'h600DF00D;
        tick();
        idle();
        en[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'd20; tick();
        addr[1] = 6'd5; tick();
        addr[1] = 6'd3; tick();
        idle(); tick(); tick();

        // Reset one cycle after a read is issued; a write during reset is dropped
        en[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'd5;
        tick();
        idle();
        assert_reset();
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 6'd5; wd[0] = 32'h0BADC0DE;
        tick();
        idle();
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        en[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'd5;
        tick();
        idle();
        chk("post_rst_u1_a5", rdat[1][0], 32'hDEADBEEF);
        tick();
        chk("post_rst_u0_a5", rdat[0][0], 32'hDEADBEEF);

        // Random traffic, narrow address range to force collisions
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 2; p++) begin
                en[p]   = 1'($urandom_range(0, 3) != 0);
                we[p]   = 1'($urandom_range(0, 1));
                be[p]   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
                addr[p] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
                wd[p]   = $urandom;
            end
            tick();
        end
        idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
